// File: rtl/sbus_mem_responder_if.sv
// ---------------------------------------------------------------------------
// sbus_mem_responder_if
//   SBUS signal bundle between the MBOX (cycle initiator) and one
//   core-memory controller (responder).
//
//   Initiator -> responder:
//     START     cycle request, held until ACKN is seen
//     RD_RQ     read requested
//     WR_RQ     write requested
//     RQ[3:0]   quad word mask, bit i selects word i of the quad
//     ADR[21:0] physical word address, [1:0] = starting word in quad
//     D_IN      write data word
//     D_PAR_IN  even parity of D_IN
//     DV_IN     write data valid
//   Responder -> initiator:
//     ACKN        one-cycle acknowledge
//     DATA_VALID  read word valid
//     D_OUT       read data word
//     D_PAR       even parity of D_OUT
//     WD[1:0]     quad word index of the current read or write word
//     ERROR       one-cycle error pulse
//     BUSY        cycle in progress
// ---------------------------------------------------------------------------
interface sbus_mem_responder_if;
    logic        START;
    logic        RD_RQ;
    logic        WR_RQ;
    logic [3:0]  RQ;
    logic [21:0] ADR;
    logic [35:0] D_IN;
    logic        D_PAR_IN;
    logic        DV_IN;
    logic        ACKN;
    logic        DATA_VALID;
    logic [35:0] D_OUT;
    logic        D_PAR;
    logic [1:0]  WD;
    logic        ERROR;
    logic        BUSY;

    modport master (
        output START, RD_RQ, WR_RQ, RQ, ADR, D_IN, D_PAR_IN, DV_IN,
        input  ACKN, DATA_VALID, D_OUT, D_PAR, WD, ERROR, BUSY
    );

    modport slave (
        input  START, RD_RQ, WR_RQ, RQ, ADR, D_IN, D_PAR_IN, DV_IN,
        output ACKN, DATA_VALID, D_OUT, D_PAR, WD, ERROR, BUSY
    );
endinterface

// File: rtl/sbus_mem_responder.sv
// ---------------------------------------------------------------------------
// sbus_mem_responder
//   Memory-side SBUS responder modelling one internal-memory controller.
//   Accepts a START with RD/WR request and a quad word mask, acknowledges
//   after ACK_DLY cycles, streams masked read words after RD_DLY cycles,
//   then (for read-pause-write, or plain write) absorbs one write word per
//   DV_IN with parity checking and a per-word timeout.
//
//   Ports:
//     clk       SBUS/MBOX clock
//     CROBAR_N  asynchronous active-low reset (memory array is kept)
//     bus       sbus_mem_responder_if.slave, see the interface header
//
//   Parameters:
//     ADR_BITS    implemented word-address width
//     ACK_DLY     cycles from accepted START to ACKN (>= 1)
//     RD_DLY      cycles from ACKN to first read DATA_VALID (>= 1)
//     WR_TIMEOUT  max cycles to wait for each write DV_IN
// ---------------------------------------------------------------------------
module sbus_mem_responder #(
    parameter int ADR_BITS   = 14,
    parameter int ACK_DLY    = 2,
    parameter int RD_DLY     = 3,
    parameter int WR_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 CROBAR_N,
    sbus_mem_responder_if.slave  bus
);

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ACKW,
        RDLAT,
        RDX,
        WRX,
        DONE
    } state_t;

    // First word position at or after 'from' (mod 4) whose mask bit is set.
    // Scanning from the far end lets the nearest hit win.
    function automatic logic [1:0] next_idx(input logic [1:0] from,
                                            input logic [3:0] m);
        logic [1:0] r;
        logic [1:0] c;
        r = from;
        for (int k = 3; k >= 0; k--) begin
            c = from + 2'(k);
            if (m[c]) r = c;
        end
        return r;
    endfunction

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_tmr;
    logic [ADR_BITS-3:0]    r_base;
    logic [1:0]             r_start;
    logic [3:0]             r_rq;
    logic                   r_rd;
    logic                   r_wr;
    logic [1:0]             r_idx;
    logic [3:0]             r_left;
    logic                   r_ackn;
    logic                   r_dv;
    logic [35:0]            r_dout;
    logic                   r_dpar;
    logic [1:0]             r_wd;
    logic                   r_err;
    logic                   r_busy;

    logic [35:0]            r_mem [2**ADR_BITS];

    logic                   w_nxm;
    logic                   w_par_ok;
    logic [3:0]             w_left_n;
    logic [1:0]             w_next;
    logic [1:0]             w_first;
    logic [ADR_BITS-1:0]    w_maddr;
    logic [35:0]            w_rdata;
    logic                   w_we;

    // Any address bit above the implemented range means no memory answers.
    assign w_nxm    = |bus.ADR[21:ADR_BITS];
    assign w_par_ok = ((^bus.D_IN) == bus.D_PAR_IN);
    // Remaining mask with the current word retired, and the word after it.
    assign w_left_n = r_left & ~(4'b0001 << r_idx);
    assign w_next   = next_idx(r_idx + 2'd1, w_left_n);
    assign w_first  = next_idx(r_start, r_rq);
    // Quad base is fixed for the whole cycle; only the word index moves.
    assign w_maddr  = {r_base, r_idx};
    assign w_rdata  = r_mem[w_maddr];
    assign w_we     = (r_state == WRX) && bus.DV_IN && w_par_ok;

    // Memory array has no reset so contents survive CROBAR_N.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_maddr] <= bus.D_IN;
    end

    always_ff @(posedge clk or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tmr   <= '0;
            r_base  <= '0;
            r_start <= '0;
            r_rq    <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_idx   <= '0;
            r_left  <= '0;
            r_ackn  <= 1'b0;
            r_dv    <= 1'b0;
            r_dout  <= '0;
            r_dpar  <= 1'b0;
            r_wd    <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // Pulses and read-data outputs default low every cycle.
            r_ackn <= 1'b0;
            r_err  <= 1'b0;
            r_dv   <= 1'b0;
            r_dout <= '0;
            r_dpar <= 1'b0;
            r_wd   <= '0;

            case (r_state)
                IDLE: begin
                    if (bus.START && (bus.RD_RQ || bus.WR_RQ)) begin
                        r_base  <= bus.ADR[ADR_BITS-1:2];
                        r_start <= bus.ADR[1:0];
                        r_rq    <= bus.RQ;
                        r_rd    <= bus.RD_RQ;
                        r_wr    <= bus.WR_RQ;
                        r_busy  <= 1'b1;
                        if (w_nxm) begin
                            r_state <= DONE;
                        end else begin
                            r_cnt   <= CNT_W'(ACK_DLY - 1);
                            r_state <= ACKW;
                        end
                    end
                end

                ACKW: begin
                    if (r_cnt == '0) begin
                        r_ackn <= 1'b1;
                        r_idx  <= w_first;
                        r_left <= r_rq;
                        if (r_rq == 4'b0000) begin
                            r_state <= DONE;
                        end else if (r_rd) begin
                            r_cnt   <= CNT_W'(RD_DLY - 1);
                            r_state <= RDLAT;
                        end else begin
                            r_tmr   <= '0;
                            r_wd    <= w_first;
                            r_state <= WRX;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                // RDLAT emits the first word on its last count; RDX emits
                // one word every cycle after that.
                RDLAT, RDX: begin
                    if ((r_state == RDX) || (r_cnt == '0)) begin
                        r_dv   <= 1'b1;
                        r_dout <= w_rdata;
                        r_dpar <= ^w_rdata;
                        r_wd   <= r_idx;
                        r_left <= w_left_n;
                        if (w_left_n == 4'b0000) begin
                            if (r_wr) begin
                                // Read-pause-write: rewalk the same mask.
                                r_left  <= r_rq;
                                r_idx   <= w_first;
                                r_tmr   <= '0;
                                r_state <= WRX;
                            end else begin
                                r_state <= DONE;
                            end
                        end else begin
                            r_idx   <= w_next;
                            r_state <= RDX;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                WRX: begin
                    r_wd <= r_idx;
                    if (bus.DV_IN) begin
                        r_tmr <= '0;
                        // Bad parity drops the word but the transfer goes on.
                        if (!w_par_ok) r_err <= 1'b1;
                        r_left <= w_left_n;
                        if (w_left_n == 4'b0000) begin
                            r_wd    <= '0;
                            r_state <= DONE;
                        end else begin
                            r_idx <= w_next;
                            r_wd  <= w_next;
                        end
                    end else if (r_tmr == CNT_W'(WR_TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_wd    <= '0;
                        r_state <= DONE;
                    end else begin
                        r_tmr <= r_tmr + CNT_W'(1);
                    end
                end

                DONE: begin
                    if (!bus.START) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ACKN       = r_ackn;
    assign bus.DATA_VALID = r_dv;
    assign bus.D_OUT      = r_dout;
    assign bus.D_PAR      = r_dpar;
    assign bus.WD         = r_wd;
    assign bus.ERROR      = r_err;
    assign bus.BUSY       = r_busy;

endmodule
